// File: rtl/cla_pkg.sv
// Shared constants and constant functions for the pipelined CLA adder/subtractor.
// Saturation limits are built at a fixed maximum width and sliced by the user.
package cla_pkg;

   localparam logic        OP_ADD    = 1'b0;
   localparam logic        OP_SUB    = 1'b1;
   localparam int unsigned CLA_MAX_W = 256;

   function automatic int unsigned ngrp(input int unsigned width, input int unsigned grp);
      return (width + grp - 32'd1) / grp;
   endfunction

   function automatic logic [CLA_MAX_W-1:0] sat_max(input int unsigned width);
      logic [CLA_MAX_W-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < CLA_MAX_W; i++) begin
         if (i + 32'd1 < width) begin
            v[i] = 1'b1;
         end else begin
            v[i] = 1'b0;
         end
      end
      return v;
   endfunction

   function automatic logic [CLA_MAX_W-1:0] sat_min(input int unsigned width);
      logic [CLA_MAX_W-1:0] v;
      v = '0;
      v[width - 32'd1] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational W-bit carry-lookahead group: group generate/propagate and
// both candidate sums (carry-in 0 and carry-in 1) for later carry-select.
module cla_group
   import cla_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic         o_g,
   output logic         o_p,
   output logic [W-1:0] o_sum0,
   output logic [W-1:0] o_sum1
);

   logic [W-1:0] w_g;
   logic [W-1:0] w_p;
   logic [W:0]   w_c0;
   logic [W:0]   w_c1;
   logic         w_pp;
   logic         w_term;

   // Flattened lookahead: each carry is an OR of generate terms gated by the
   // propagate run above it, plus the full propagate run for the cin=1 case.
   always_comb begin
      w_g    = i_a & i_b;
      w_p    = i_a ^ i_b;
      w_c0   = '0;
      w_c1   = '0;
      w_pp   = 1'b1;
      w_term = 1'b0;
      w_c1[0] = 1'b1;
      for (int i = 1; i <= int'(W); i++) begin
         w_pp   = 1'b1;
         w_term = 1'b0;
         for (int j = i - 1; j >= 0; j--) begin
            w_term = w_term | (w_g[j] & w_pp);
            w_pp   = w_pp & w_p[j];
         end
         w_c0[i] = w_term;
         w_c1[i] = w_term | w_pp;
      end
   end

   assign o_g    = w_c0[W];
   assign o_p    = &w_p;
   assign o_sum0 = w_p ^ w_c0[W-1:0];
   assign o_sum1 = w_p ^ w_c1[W-1:0];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with optional signed
// saturation, status flags and a valid/ready handshake with backpressure.
module cla_addsub_pipe
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH = 20,
   parameter int unsigned GRP   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned NGRP = ngrp(WIDTH, GRP);
   localparam int unsigned MSB  = WIDTH - 32'd1;
   localparam logic [CLA_MAX_W-1:0] SAT_MAX_FULL = sat_max(WIDTH);
   localparam logic [CLA_MAX_W-1:0] SAT_MIN_FULL = sat_min(WIDTH);
   localparam logic [WIDTH-1:0]     SAT_MAX      = SAT_MAX_FULL[WIDTH-1:0];
   localparam logic [WIDTH-1:0]     SAT_MIN      = SAT_MIN_FULL[WIDTH-1:0];

   logic [WIDTH-1:0] w_bx;
   logic [NGRP-1:0]  w_g;
   logic [NGRP-1:0]  w_p;
   logic [WIDTH-1:0] w_sum0;
   logic [WIDTH-1:0] w_sum1;
   logic             w_accept;
   logic             w_s2_free;
   logic             w_s2_load;

   logic             r_s1_valid;
   logic [NGRP-1:0]  r_s1_g;
   logic [NGRP-1:0]  r_s1_p;
   logic [WIDTH-1:0] r_s1_sum0;
   logic [WIDTH-1:0] r_s1_sum1;
   logic             r_s1_op;
   logic             r_s1_sat;
   logic             r_s1_amsb;
   logic             r_s1_bmsb;

   logic             r_s2_valid;
   logic [WIDTH-1:0] r_res;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   logic [NGRP:0]    w_gc;
   logic [WIDTH-1:0] w_raw;
   logic [WIDTH-1:0] w_res;
   logic             w_cout;
   logic             w_ovf;
   logic             w_zero;
   logic             w_pp;
   logic             w_term;

   // Subtraction reuses the adder: invert B here, carry-in comes from op in stage 2.
   assign w_bx = b ^ {WIDTH{op}};

   genvar k;
   generate
      for (k = 0; k < NGRP; k++) begin : g_grp
         localparam int unsigned LO = k * GRP;
         localparam int unsigned GW = (k == NGRP - 1) ? (WIDTH - LO) : GRP;
         cla_group #(.W(GW)) u_grp (
            .i_a    (a[LO +: GW]),
            .i_b    (w_bx[LO +: GW]),
            .o_g    (w_g[k]),
            .o_p    (w_p[k]),
            .o_sum0 (w_sum0[LO +: GW]),
            .o_sum1 (w_sum1[LO +: GW])
         );
      end
   endgenerate

   assign w_s2_free = ~r_s2_valid | out_ready;
   assign in_ready  = (~r_s1_valid | w_s2_free) & ~flush;
   assign w_accept  = in_valid & in_ready;
   assign w_s2_load = r_s1_valid & w_s2_free & ~flush;

   // Stage 2 combinational: group-carry lookahead, carry-select, flags, clamp.
   always_comb begin
      w_gc    = '0;
      w_gc[0] = r_s1_op;
      w_pp    = 1'b1;
      w_term  = 1'b0;
      for (int i = 1; i <= int'(NGRP); i++) begin
         w_pp   = 1'b1;
         w_term = 1'b0;
         for (int j = i - 1; j >= 0; j--) begin
            w_term = w_term | (r_s1_g[j] & w_pp);
            w_pp   = w_pp & r_s1_p[j];
         end
         w_gc[i] = w_term | (w_pp & r_s1_op);
      end
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (w_gc[i / int'(GRP)]) begin
            w_raw[i] = r_s1_sum1[i];
         end else begin
            w_raw[i] = r_s1_sum0[i];
         end
      end
      w_ovf  = (r_s1_amsb == r_s1_bmsb) && (w_raw[MSB] != r_s1_amsb);
      w_cout = w_gc[NGRP] ^ r_s1_op;
      if (r_s1_sat && w_ovf) begin
         w_res = r_s1_amsb ? SAT_MIN : SAT_MAX;
      end else begin
         w_res = w_raw;
      end
      w_zero = (w_res == '0);
   end

   // Stage 1 register: per-group lookahead terms plus sign bits and controls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_g     <= '0;
         r_s1_p     <= '0;
         r_s1_sum0  <= '0;
         r_s1_sum1  <= '0;
         r_s1_op    <= 1'b0;
         r_s1_sat   <= 1'b0;
         r_s1_amsb  <= 1'b0;
         r_s1_bmsb  <= 1'b0;
      end else begin
         if (flush) begin
            r_s1_valid <= 1'b0;
         end else if (w_accept) begin
            r_s1_valid <= 1'b1;
         end else if (w_s2_free) begin
            r_s1_valid <= 1'b0;
         end else begin
            r_s1_valid <= r_s1_valid;
         end
         if (w_accept) begin
            r_s1_g    <= w_g;
            r_s1_p    <= w_p;
            r_s1_sum0 <= w_sum0;
            r_s1_sum1 <= w_sum1;
            r_s1_op   <= op;
            r_s1_sat  <= sat;
            r_s1_amsb <= a[MSB];
            r_s1_bmsb <= w_bx[MSB];
         end
      end
   end

   // Stage 2 register: the output holding stage, frozen while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_res      <= '0;
         r_cout     <= 1'b0;
         r_ovf      <= 1'b0;
         r_zero     <= 1'b0;
      end else begin
         if (flush) begin
            r_s2_valid <= 1'b0;
         end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
         end else begin
            r_s2_valid <= r_s2_valid;
         end
         if (w_s2_load) begin
            r_res  <= w_res;
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign res       = r_res;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign zero      = r_zero;

endmodule
